// File: rtl/ui_input_ctrl_if.sv
// ui_input_ctrl_if: raw board controls in, conditioned UI results out.
// The board (or a bench) sits on the master side; ui_input_ctrl sits on the slave side.
interface ui_input_ctrl_if #(
  parameter int LOG_BOARD_SIZE = 6,
  parameter int LOG_MAX_SPEED  = 4
);
  logic [15:0]               sw_in;
  logic                      btnu_in;
  logic                      btnd_in;
  logic                      btnl_in;
  logic                      btnr_in;
  logic                      btnc_in;
  logic                      click_out;
  logic [LOG_MAX_SPEED-1:0]  speed_out;
  logic [LOG_BOARD_SIZE-1:0] cursor_x_out;
  logic [LOG_BOARD_SIZE-1:0] cursor_y_out;
  logic [LOG_BOARD_SIZE-1:0] view_x_out;
  logic [LOG_BOARD_SIZE-1:0] view_y_out;

  // Board side: drives switches and buttons, observes cursor, view, speed and click.
  modport master (
    output sw_in, btnu_in, btnd_in, btnl_in, btnr_in, btnc_in,
    input  click_out, speed_out, cursor_x_out, cursor_y_out, view_x_out, view_y_out
  );

  // Controller side.
  modport slave (
    input  sw_in, btnu_in, btnd_in, btnl_in, btnr_in, btnc_in,
    output click_out, speed_out, cursor_x_out, cursor_y_out, view_x_out, view_y_out
  );
endinterface

// File: rtl/ui_input_ctrl.sv
// ui_input_ctrl: Game of Life user-control front end.
// Synchronises and debounces the five buttons, turns U/D/L/R into cursor steps with
// hold-to-repeat, emits a one-cycle click for the centre button, passes the speed
// switches through a synchroniser, and scrolls a viewport that follows the cursor
// on a toroidal N x N board (N = 2**LOG_BOARD_SIZE).
// Optional build macro UI_ACCEL_EN: from the 8th auto-repeat step of a held
// direction onward, each step moves 4 cells instead of 1.
module ui_input_ctrl #(
  parameter int LOG_BOARD_SIZE  = 6,
  parameter int LOG_MAX_SPEED   = 4,
  parameter int VIEW_W          = 16,
  parameter int VIEW_H          = 12,
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_PERIOD   = 5000000
) (
  input logic            clk_in,
  input logic            rst_in,
  ui_input_ctrl_if.slave bus
);

  localparam int LB    = LOG_BOARD_SIZE;
  localparam int N     = 1 << LB;
  localparam int NB    = 5;  // buttons: U, D, L, R, C
  localparam int ND    = 4;  // direction buttons
  localparam int BTN_U = 0;
  localparam int BTN_D = 1;
  localparam int BTN_L = 2;
  localparam int BTN_R = 3;
  localparam int BTN_C = 4;
  localparam int DBW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int RCMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW   = $clog2(RCMAX + 1);

  localparam logic [LB-1:0] CURSOR_RST = LB'(N / 2);
  localparam logic [LB-1:0] VIEW_X_RST = LB'(N / 2 - VIEW_W / 2);
  localparam logic [LB-1:0] VIEW_Y_RST = LB'(N / 2 - VIEW_H / 2);
  localparam logic [LB-1:0] VIEW_W_M1  = LB'(VIEW_W - 1);
  localparam logic [LB-1:0] VIEW_H_M1  = LB'(VIEW_H - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} dir_state_t;

  logic [NB-1:0]            w_btn_raw;
  logic [NB-1:0]            r_btn_s1;
  logic [NB-1:0]            r_btn_s2;
  logic [LOG_MAX_SPEED-1:0] r_sw_s1;
  logic [LOG_MAX_SPEED-1:0] r_speed;
  logic [DBW-1:0]           r_db_cnt [NB];
  logic [NB-1:0]            r_db;
  logic [NB-1:0]            r_db_prev;
  logic [NB-1:0]            w_rise;
  dir_state_t               r_state [ND];
  logic [RCW-1:0]           r_rcnt [ND];
  logic [ND-1:0]            r_step;
`ifdef UI_ACCEL_EN
  logic [3:0]               r_rep_cnt [ND];
  logic [ND-1:0]            r_big;
`endif
  logic [LB-1:0]            w_mag [ND];
  logic                     w_x_pos;
  logic                     w_x_neg;
  logic                     w_y_pos;
  logic                     w_y_neg;
  logic [LB-1:0]            r_cursor_x;
  logic [LB-1:0]            r_cursor_y;
  logic                     r_last_x_pos;
  logic                     r_last_y_pos;
  logic [LB-1:0]            w_dist_x;
  logic [LB-1:0]            w_dist_y;
  logic [LB-1:0]            r_view_x;
  logic [LB-1:0]            r_view_y;
  logic                     r_click;
  logic                     w_unused_sw;

  assign w_btn_raw   = {bus.btnc_in, bus.btnr_in, bus.btnl_in, bus.btnd_in, bus.btnu_in};
  assign w_unused_sw = ^bus.sw_in[15:LOG_MAX_SPEED];

  // Two-flop synchronisers for the raw buttons and the speed switches.
  always_ff @(posedge clk_in) begin
    // NOTE: sequential state is always assigned with <= so every flop samples the
    // pre-edge value of its neighbours, exactly like the hardware pipeline.
    if (rst_in) begin
      r_btn_s1 <= '0;
      r_btn_s2 <= '0;
      r_sw_s1  <= '0;
      r_speed  <= '0;
    end else begin
      r_btn_s1 <= w_btn_raw;
      r_btn_s2 <= r_btn_s1;
      r_sw_s1  <= bus.sw_in[LOG_MAX_SPEED-1:0];
      r_speed  <= r_sw_s1;
    end
  end

  // Debouncers: a level follows its synchronised input only after DEBOUNCE_CYCLES
  // consecutive disagreeing cycles; any agreeing cycle restarts the count.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_db      <= '0;
      r_db_prev <= '0;
      // NOTE: these small counter arrays are plain flops, not a RAM, so they are
      // reset like any other register.
      for (int i = 0; i < NB; i++) r_db_cnt[i] <= '0;
    end else begin
      r_db_prev <= r_db;
      for (int i = 0; i < NB; i++) begin
        if (r_btn_s2[i] == r_db[i]) begin
          r_db_cnt[i] <= '0;
        end else if (r_db_cnt[i] == DBW'(DEBOUNCE_CYCLES - 1)) begin
          r_db[i]     <= r_btn_s2[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DBW'(1);
        end
      end
    end
  end

  assign w_rise = r_db & ~r_db_prev;

  // Direction FSMs: step on press, again after REPEAT_DELAY, then every REPEAT_PERIOD.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_step <= '0;
      for (int i = 0; i < ND; i++) begin
        r_state[i] <= ST_IDLE;
        r_rcnt[i]  <= '0;
      end
`ifdef UI_ACCEL_EN
      r_big <= '0;
      for (int i = 0; i < ND; i++) r_rep_cnt[i] <= '0;
`endif
    end else begin
      for (int i = 0; i < ND; i++) begin
        r_step[i] <= 1'b0;
`ifdef UI_ACCEL_EN
        r_big[i]  <= 1'b0;
`endif
        if (!r_db[i]) begin
          r_state[i] <= ST_IDLE;
          r_rcnt[i]  <= '0;
`ifdef UI_ACCEL_EN
          r_rep_cnt[i] <= '0;
`endif
        end else begin
          case (r_state[i])
            ST_IDLE: begin
              if (w_rise[i]) begin
                r_step[i]  <= 1'b1;
                r_state[i] <= ST_DELAY;
                r_rcnt[i]  <= '0;
              end
            end
            ST_DELAY: begin
              if (r_rcnt[i] == RCW'(REPEAT_DELAY - 1)) begin
                r_step[i]  <= 1'b1;
                r_state[i] <= ST_REPEAT;
                r_rcnt[i]  <= '0;
              end else begin
                r_rcnt[i] <= r_rcnt[i] + RCW'(1);
              end
            end
            ST_REPEAT: begin
              if (r_rcnt[i] == RCW'(REPEAT_PERIOD - 1)) begin
                r_step[i] <= 1'b1;
                r_rcnt[i] <= '0;
`ifdef UI_ACCEL_EN
                // Repeats seen so far saturate at 8; the 8th and later are large steps.
                if (r_rep_cnt[i] != 4'd8) r_rep_cnt[i] <= r_rep_cnt[i] + 4'd1;
                r_big[i] <= (r_rep_cnt[i] >= 4'd7);
`endif
              end else begin
                r_rcnt[i] <= r_rcnt[i] + RCW'(1);
              end
            end
            default: r_state[i] <= ST_IDLE;
          endcase
        end
      end
    end
  end

  // Step magnitude per direction for this cycle (0 when no step is emitted).
  always_comb begin
    for (int i = 0; i < ND; i++) begin
      // NOTE: default first so every path assigns w_mag and no latch is inferred.
      w_mag[i] = '0;
      if (r_step[i]) begin
`ifdef UI_ACCEL_EN
        w_mag[i] = r_big[i] ? LB'(4) : LB'(1);
`else
        w_mag[i] = LB'(1);
`endif
      end
    end
  end

  assign w_x_pos = (w_mag[BTN_R] > w_mag[BTN_L]);
  assign w_x_neg = (w_mag[BTN_R] < w_mag[BTN_L]);
  assign w_y_pos = (w_mag[BTN_D] > w_mag[BTN_U]);
  assign w_y_neg = (w_mag[BTN_D] < w_mag[BTN_U]);

  // Cursor: apply this cycle's steps; opposite steps cancel; natural wrap mod N.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_cursor_x   <= CURSOR_RST;
      r_cursor_y   <= CURSOR_RST;
      r_last_x_pos <= 1'b0;
      r_last_y_pos <= 1'b0;
    end else begin
      r_cursor_x <= r_cursor_x + w_mag[BTN_R] - w_mag[BTN_L];
      r_cursor_y <= r_cursor_y + w_mag[BTN_D] - w_mag[BTN_U];
      if (w_x_pos)      r_last_x_pos <= 1'b1;
      else if (w_x_neg) r_last_x_pos <= 1'b0;
      if (w_y_pos)      r_last_y_pos <= 1'b1;
      else if (w_y_neg) r_last_y_pos <= 1'b0;
    end
  end

  assign w_dist_x = r_cursor_x - r_view_x;
  assign w_dist_y = r_cursor_y - r_view_y;

  // Viewport: when the cursor falls outside the window, snap the leading edge onto it.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_view_x <= VIEW_X_RST;
      r_view_y <= VIEW_Y_RST;
    end else begin
      if (32'(w_dist_x) >= 32'(VIEW_W))
        r_view_x <= r_last_x_pos ? (r_cursor_x - VIEW_W_M1) : r_cursor_x;
      if (32'(w_dist_y) >= 32'(VIEW_H))
        r_view_y <= r_last_y_pos ? (r_cursor_y - VIEW_H_M1) : r_cursor_y;
    end
  end

  // Click: one cycle after the centre button's debounced rising edge.
  always_ff @(posedge clk_in) begin
    if (rst_in) r_click <= 1'b0;
    else        r_click <= w_rise[BTN_C];
  end

  assign bus.click_out    = r_click;
  assign bus.speed_out    = r_speed;
  assign bus.cursor_x_out = r_cursor_x;
  assign bus.cursor_y_out = r_cursor_y;
  assign bus.view_x_out   = r_view_x;
  assign bus.view_y_out   = r_view_y;

endmodule

// File: tb/tb_ui_input_ctrl.sv
// tb_ui_input_ctrl: scoreboard bench for ui_input_ctrl with small timing parameters.
// A behavioural model predicts every output each cycle; a monitor compares on the
// opposite clock edge. Directed checks cover the headline scenarios.
module tb_ui_input_ctrl;

  localparam int LBS = 6;
  localparam int LMS = 4;
  localparam int N   = 1 << LBS;
  localparam int VW  = 16;
  localparam int VH  = 12;
  localparam int DEB = 4;
  localparam int DLY = 10;
  localparam int PER = 3;
  localparam int WIN_MASK = (1 << DEB) - 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [4:0]  btn = '0;   // {c, r, l, d, u}
  logic [15:0] sw  = '0;

  int n_cmp  = 0;
  int n_fail = 0;

  ui_input_ctrl_if #(.LOG_BOARD_SIZE(LBS), .LOG_MAX_SPEED(LMS)) bus ();

  assign bus.btnu_in = btn[0];
  assign bus.btnd_in = btn[1];
  assign bus.btnl_in = btn[2];
  assign bus.btnr_in = btn[3];
  assign bus.btnc_in = btn[4];
  assign bus.sw_in   = sw;

  ui_input_ctrl #(
    .LOG_BOARD_SIZE(LBS), .LOG_MAX_SPEED(LMS), .VIEW_W(VW), .VIEW_H(VH),
    .DEBOUNCE_CYCLES(DEB), .REPEAT_DELAY(DLY), .REPEAT_PERIOD(PER)
  ) dut (
    .clk_in(clk),
    .rst_in(rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic       click;
    logic [3:0] speed;
    logic [5:0] cx, cy, vx, vy;
  } obs_t;

  obs_t exp_q[$];

  bit [4:0] m_s1, m_s2, m_db;
  int       m_win [5];     // last DEB synchronised samples per button
  int       m_hold [5];    // consecutive cycles the debounced level has been high
  int       m_amt [4];     // cells each direction moves on the next cycle
  int       m_cx, m_cy, m_vx, m_vy;
  bit       m_x_pos, m_y_pos, m_click;
  bit [3:0] m_sw1, m_speed;

  function automatic int wrap(input int v);
    return ((v % N) + N) % N;
  endfunction

  // Cells moved when a level has been high for h cycles (0 = no step this cycle).
  function automatic int step_amount(input int h);
    if (h == 1) return 1;
    if (h - 1 >= DLY && (h - 1 - DLY) % PER == 0) begin
`ifdef UI_ACCEL_EN
      if ((h - 1 - DLY) / PER >= 8) return 4;
`endif
      return 1;
    end
    return 0;
  endfunction

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_db = '0;
    for (int b = 0; b < 5; b++) begin m_win[b] = 0; m_hold[b] = 0; end
    for (int d = 0; d < 4; d++) m_amt[d] = 0;
    m_cx = N / 2; m_cy = N / 2;
    m_vx = wrap(N / 2 - VW / 2); m_vy = wrap(N / 2 - VH / 2);
    m_x_pos = 0; m_y_pos = 0; m_click = 0;
    m_sw1 = '0; m_speed = '0;
  endtask

  always @(posedge clk) begin
    bit [4:0] db_old;
    int dx, dy;
    obs_t o;
    if (rst) begin
      model_reset();
    end else begin
      db_old = m_db;
      // viewport follows the cursor position from the previous cycle
      if (wrap(m_cx - m_vx) >= VW) m_vx = m_x_pos ? wrap(m_cx - VW + 1) : m_cx;
      if (wrap(m_cy - m_vy) >= VH) m_vy = m_y_pos ? wrap(m_cy - VH + 1) : m_cy;
      // cursor applies the steps emitted in the previous cycle
      dx = m_amt[3] - m_amt[2];
      dy = m_amt[1] - m_amt[0];
      m_cx = wrap(m_cx + dx);
      m_cy = wrap(m_cy + dy);
      if (dx > 0) m_x_pos = 1; else if (dx < 0) m_x_pos = 0;
      if (dy > 0) m_y_pos = 1; else if (dy < 0) m_y_pos = 0;
      // steps and click from how long each debounced level has been high
      for (int b = 0; b < 5; b++) m_hold[b] = db_old[b] ? m_hold[b] + 1 : 0;
      for (int d = 0; d < 4; d++) m_amt[d] = db_old[d] ? step_amount(m_hold[d]) : 0;
      m_click = db_old[4] && (m_hold[4] == 1);
      // debounced level flips when the last DEB samples all disagree with it
      for (int b = 0; b < 5; b++) begin
        m_win[b] = ((m_win[b] << 1) | int'(m_s2[b])) & WIN_MASK;
        if (m_win[b] == (m_db[b] ? 0 : WIN_MASK)) m_db[b] = ~m_db[b];
      end
      m_s2 = m_s1;
      m_s1 = btn;
      m_speed = m_sw1;
      m_sw1 = sw[3:0];
    end
    o.click = m_click; o.speed = m_speed;
    o.cx = 6'(m_cx); o.cy = 6'(m_cy); o.vx = 6'(m_vx); o.vy = 6'(m_vy);
    exp_q.push_back(o);
  end

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    obs_t e;
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check("sb_click",    32'(bus.click_out),    32'(e.click));
      check("sb_speed",    32'(bus.speed_out),    32'(e.speed));
      check("sb_cursor_x", 32'(bus.cursor_x_out), 32'(e.cx));
      check("sb_cursor_y", 32'(bus.cursor_y_out), 32'(e.cy));
      check("sb_view_x",   32'(bus.view_x_out),   32'(e.vx));
      check("sb_view_y",   32'(bus.view_y_out),   32'(e.vy));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_x(input logic [5:0] target, input int budget, input string name);
    int n = 0;
    while (bus.cursor_x_out !== target && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.cursor_x_out === target), 32'd1);
  endtask

  task automatic wait_x_change(input int budget, input string name);
    logic [5:0] start;
    int n = 0;
    start = bus.cursor_x_out;
    while (bus.cursor_x_out === start && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(name, 32'(bus.cursor_x_out !== start), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_cursor_x"}, 32'(bus.cursor_x_out), 32);
    check({tag, "_cursor_y"}, 32'(bus.cursor_y_out), 32);
    check({tag, "_view_x"},   32'(bus.view_x_out),   24);
    check({tag, "_view_y"},   32'(bus.view_y_out),   26);
    check({tag, "_click"},    32'(bus.click_out),    0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] y0, x0;
    int clicks;
    int r, b;

    // 1. reset values
    cycles(3);
    check_reset_values("rst");
    check("rst_speed", 32'(bus.speed_out), 0);
    rst = 1'b0;

    // 2. bouncing press then hold: one step, then delay, then periodic repeat
    btn[3] = 1'b1; cycles(1);
    btn[3] = 1'b0; cycles(1);
    btn[3] = 1'b1;
    wait_x(33, 20, "first_step");
    cycles(DLY - 1);
    check("no_early_repeat", 32'(bus.cursor_x_out), 33);
    cycles(1);
    check("delay_step", 32'(bus.cursor_x_out), 34);
    cycles(PER);
    check("repeat_1", 32'(bus.cursor_x_out), 35);
    cycles(PER);
    check("repeat_2", 32'(bus.cursor_x_out), 36);
    btn[3] = 1'b0;
    cycles(12);
    x0 = bus.cursor_x_out;
    cycles(20);
    check("stops_on_release", 32'(bus.cursor_x_out), 32'(x0));

    // 3. leftward wrap through column 0, then opposite vertical presses cancel
    btn[2] = 1'b1;
`ifndef UI_ACCEL_EN
    wait_x(0, 600, "reach_x0");
    wait_x_change(20, "leave_x0");
    check("wrap_x", 32'(bus.cursor_x_out), 63);
    check("view_before_wrap", 32'(bus.view_x_out), 0);
    cycles(1);
    check("view_wrap_x", 32'(bus.view_x_out), 63);
`else
    cycles(150);
`endif
    btn[2] = 1'b0;
    cycles(15);
    y0 = bus.cursor_y_out;
    btn[1:0] = 2'b11;
    cycles(40);
    btn[1:0] = 2'b00;
    cycles(15);
    check("ud_cancel", 32'(bus.cursor_y_out), 32'(y0));

    // 4. viewport scroll to the right
    rst = 1'b1; cycles(1); rst = 1'b0;
    btn[3] = 1'b1;
    wait_x(40, 200, "reach_x40");
    check("view_lags_cursor", 32'(bus.view_x_out), 24);
    cycles(1);
    check("view_scroll", 32'(bus.view_x_out), 25);
    wait_x(45, 200, "reach_x45");
    cycles(1);
    check("view_tracks", 32'(bus.view_x_out), 30);
    btn[3] = 1'b0;
    cycles(15);

    // 5. click is a single pulse; speed has two cycles of latency
    clicks = 0;
    btn[4] = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (bus.click_out === 1'b1) clicks++;
    end
    btn[4] = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.click_out === 1'b1) clicks++;
    end
    check("click_once", 32'(clicks), 1);
    sw = 16'h000A;
    cycles(1);
    check("speed_latency_1", 32'(bus.speed_out), 0);
    cycles(1);
    check("speed_latency_2", 32'(bus.speed_out), 10);

    // 6. reset mid-repeat with the button still held
    btn[3] = 1'b1;
    cycles(40);
    rst = 1'b1; cycles(1);
    check_reset_values("midrst");
    rst = 1'b0;
    wait_x(33, 20, "fresh_step");
    cycles(DLY - 1);
    check("fresh_delay", 32'(bus.cursor_x_out), 33);
    wait_x(41, 100, "reach_x41");
    wait_x_change(20, "eighth_repeat");
`ifdef UI_ACCEL_EN
    check("eighth_repeat_size", 32'(bus.cursor_x_out), 45);
`else
    check("eighth_repeat_size", 32'(bus.cursor_x_out), 42);
`endif
    btn[3] = 1'b0;
    cycles(15);

    // 7. random presses, bounces, switch changes and occasional resets
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r = $urandom_range(0, 99);
      b = $urandom_range(0, 4);
      if (r < 3) begin
        btn[b] = ~btn[b];
      end else if (r == 3) begin
        sw = 16'($urandom);
      end else if (r == 4) begin
        btn[b] = ~btn[b];
        @(negedge clk);
        btn[b] = ~btn[b];
      end else if (r == 5 && $urandom_range(0, 9) == 0) begin
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
      end
    end
    btn = '0;
    cycles(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ui_input_ctrl.md
Name: ui_input_ctrl

Overview:
Parametrised next-generation front end for the Game of Life user controls. Turns raw board buttons and switches into the following outputs:
- Debounced cursor movement with hold-to-repeat.
- A single-cycle cell-toggle click.
- Simulation speed.
- A scrolling viewport that follows the cursor across a toroidal board.

Sits between the board I/O pins and the life engine / display pipeline. Board and view dimensions are parameters, not fixed constants.

Parameters:
LOG_BOARD_SIZE, 6, log2 of board edge length N; coordinates wrap mod N
LOG_MAX_SPEED, 4, width of speed_out
VIEW_W, 16, viewport width in cells, 1..N
VIEW_H, 12, viewport height in cells, 1..N
DEBOUNCE_CYCLES, 500000, consecutive stable cycles before a debounced level changes
REPEAT_DELAY, 25000000, cycles a direction is held before the first auto-repeat step
REPEAT_PERIOD, 5000000, cycles between subsequent auto-repeat steps

Ports:
clk_in  input  1  system clock
rst_in  input  1  synchronous active-high reset
sw_in  input  16  slide switches; [LOG_MAX_SPEED-1:0] = speed
btnu_in  input  1  raw up button (y-1)
btnd_in  input  1  raw down button (y+1)
btnl_in  input  1  raw left button (x-1)
btnr_in  input  1  raw right button (x+1)
btnc_in  input  1  raw centre button (click)
click_out  output  1  one-cycle pulse per centre press
speed_out  output  LOG_MAX_SPEED  registered speed
cursor_x_out  output  LOG_BOARD_SIZE  cursor column
cursor_y_out  output  LOG_BOARD_SIZE  cursor row
view_x_out  output  LOG_BOARD_SIZE  viewport left column
view_y_out  output  LOG_BOARD_SIZE  viewport top row

Behaviour:
- One clock (clk_in); reset synchronous, active-high (rst_in).
- Reset values:
  - click_out=0, speed_out=0.
  - cursor_x/y = N/2.
  - view_x = N/2 - VIEW_W/2 mod N; view_y = N/2 - VIEW_H/2 mod N.
  - All debounced levels 0, all FSMs IDLE, all counters 0.
- Input conditioning, per button:
  - 2-flop synchroniser, then debouncer.
  - Debounced level flips only after the synchronised input differs from it for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle clears the counter.
  - A button held through reset is seen as a fresh press once debounced after reset.
- Direction FSM, one per U/D/L/R; states IDLE, DELAY, REPEAT:
  - IDLE: on debounced rising edge -> emit step, go DELAY, clear counter.
  - DELAY: counter reaches REPEAT_DELAY-1 -> emit step, go REPEAT, clear counter.
  - REPEAT: counter reaches REPEAT_PERIOD-1 -> emit step, clear counter.
  - Any state: debounced level 0 -> IDLE (no step).
- Cursor update:
  - Registered; updates the cycle after a step is emitted.
  - Per axis: delta = (+step) - (-step). Opposite steps in the same cycle cancel. U+L etc. in the same cycle both apply.
  - Arithmetic is mod N, natural LOG_BOARD_SIZE-bit wrap: 0-1 -> N-1, N-1+1 -> 0.
- Viewport:
  - Updates one cycle after the cursor.
  - Per axis, d = (cursor - view) mod N.
  - If d >= VIEW_W (resp. VIEW_H): last move + -> view = cursor - VIEW_W + 1; last move - -> view = cursor.
  - Otherwise view is unchanged. View also wraps mod N.
  - VIEW_W == N: view never moves.
- Click:
  - click_out high exactly one cycle, the cycle after the btnc debounced rising edge.
  - No auto-repeat; release produces nothing.
- speed_out: sw_in[LOG_MAX_SPEED-1:0] through the 2-flop synchroniser; 2-cycle latency, no debounce.
- Reset asserted mid-hold or mid-count: everything returns to reset values the next cycle; no step or click is emitted in that cycle.

Optional Feature:
UI_ACCEL_EN
- Defined:
  - Each direction FSM counts REPEAT steps (saturating at 8).
  - From the 8th repeat onward, step magnitude = 4 cells instead of 1; wrap and viewport rules apply with that magnitude.
  - Counter clears on return to IDLE.
- Undefined: step magnitude is always 1; no repeat-count logic is synthesised.

Test Plan:
Bench parameters for all scenarios: LOG_BOARD_SIZE=6, VIEW_W=16, VIEW_H=12, DEBOUNCE=4, DELAY=10, PERIOD=3.
1. Reset -> cursor=(32,32), view=(24,26), click_out=0, speed_out=0.
2. btnr bounces 1,0,1 for 3 cycles then holds 1 -> exactly one step, cursor_x 32->33. After the further 10 cycles held: 34. Then +1 every 3 cycles. Release -> stops.
3. btnl held from cursor_x=0 (view_x=0) -> cursor_x 63 and view_x 63 one cycle later. btnu and btnd pressed in the same cycle -> cursor_y unchanged.
4. btnr held from (32,32), view 24 -> at cursor_x=40, view_x becomes 25 (d=16); d then tracks at 15 while held.
5. btnc held 50 cycles -> click_out high exactly one cycle. sw_in[3:0]=4'b1010 -> speed_out=10 two cycles later.
6. rst_in pulsed during REPEAT with btnr still held -> reset values, then one fresh step after debounce. With UI_ACCEL_EN: the 8th repeat advances by 4.
